// File: rtl/qpsk_frame_ser.sv
// QPSK frame serializer: sends a latched 40-bit frame as 20 (I,Q) symbols of SYM_DIV cycles each, then GAP_SYM idle symbols.
// Symbol 0 appears one cycle after start_i is sampled in IDLE; requests arriving while busy are dropped, not held.
module qpsk_frame_ser #(
    parameter int SYM_DIV = 50,
    parameter int GAP_SYM = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [39:0] para_i,
    input  logic        start_i,
    output logic        i_o,
    output logic        q_o,
    output logic        sym_en_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam int GAP_LEN = GAP_SYM * SYM_DIV;
    localparam int CW      = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
    localparam int GW      = (GAP_LEN > 1) ? $clog2(GAP_LEN + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SYM_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);
    localparam logic          HAS_GAP  = (GAP_SYM != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [4:0]    sidx, sidx_nx;
    logic [GW-1:0] gcnt, gcnt_nx;
    logic [39:0]   sreg, sreg_nx;
    logic          i_nx, q_nx, sym_en_nx, busy_nx, done_nx;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        sidx_nx   = sidx;
        gcnt_nx   = gcnt;
        sreg_nx   = sreg;
        i_nx      = i_o;
        q_nx      = q_o;
        sym_en_nx = 1'b0;
        busy_nx   = busy_o;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                i_nx    = 1'b0;
                q_nx    = 1'b0;
                busy_nx = 1'b0;
                if (start_i) begin
                    // Symbol 0 is taken straight from para_i so it is on air in the first SEND cycle.
                    sreg_nx   = para_i;
                    i_nx      = para_i[39];
                    q_nx      = para_i[38];
                    sym_en_nx = 1'b1;
                    busy_nx   = 1'b1;
                    cnt_nx    = '0;
                    sidx_nx   = '0;
                    state_nx  = SEND;
                end
            end
            SEND: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                    if (sidx == 5'd19) begin
                        i_nx    = 1'b0;
                        q_nx    = 1'b0;
                        done_nx = 1'b1;
                        gcnt_nx = '0;
                        if (HAS_GAP) begin
                            state_nx = GAP;
                        end else begin
                            busy_nx  = 1'b0;
                            state_nx = IDLE;
                        end
                    end else begin
                        sreg_nx   = {sreg[37:0], 2'b00};
                        i_nx      = sreg[37];
                        q_nx      = sreg[36];
                        sym_en_nx = 1'b1;
                        sidx_nx   = sidx + 5'd1;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) begin
                    gcnt_nx  = '0;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    gcnt_nx = gcnt + GW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sidx         <= '0;
            gcnt         <= '0;
            sreg         <= '0;
            i_o          <= 1'b0;
            q_o          <= 1'b0;
            sym_en_o     <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            sidx         <= sidx_nx;
            gcnt         <= gcnt_nx;
            sreg         <= sreg_nx;
            i_o          <= i_nx;
            q_o          <= q_nx;
            sym_en_o     <= sym_en_nx;
            busy_o       <= busy_nx;
            frame_done_o <= done_nx;
        end
    end

endmodule

// File: tb/tb_qpsk_frame_ser.sv
// Bench for qpsk_frame_ser: two instances (SYM_DIV=4/GAP_SYM=2 and SYM_DIV=2/GAP_SYM=0) checked cycle by cycle.
module tb_qpsk_frame_ser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, i_a, q_a, se_a, busy_a, done_a;
    logic        rst_b, start_b, i_b, q_b, se_b, busy_b, done_b;
    logic [39:0] para_a, para_b;

    qpsk_frame_ser #(.SYM_DIV(4), .GAP_SYM(2)) dut_a (
        .sys_clk(clk), .sys_rst(rst_a), .para_i(para_a), .start_i(start_a),
        .i_o(i_a), .q_o(q_a), .sym_en_o(se_a), .busy_o(busy_a), .frame_done_o(done_a)
    );

    qpsk_frame_ser #(.SYM_DIV(2), .GAP_SYM(0)) dut_b (
        .sys_clk(clk), .sys_rst(rst_b), .para_i(para_b), .start_i(start_b),
        .i_o(i_b), .q_o(q_b), .sym_en_o(se_b), .busy_o(busy_b), .frame_done_o(done_b)
    );

    int total = 0;
    int bad   = 0;

    int         n_sym, done_off, busy_fall;
    logic [1:0] cap [20];
    logic [39:0] hist [0:511];

    // Expected {i, q, sym_en, busy, frame_done} at cycle offset 'off' after a frame latches 'f'.
    function automatic logic [4:0] model(input logic [39:0] f, input int off, input int sd, input int gs);
        logic [4:0] v;
        int k;
        v = '0;
        if (off < 0) return v;
        if (off < 20 * sd) begin
            k    = off / sd;
            v[4] = f[39 - 2 * k];
            v[3] = f[38 - 2 * k];
            v[2] = ((off % sd) == 0);
            v[1] = 1'b1;
        end else if (off == 20 * sd) begin
            v[0] = 1'b1;
            v[1] = (gs != 0);
        end else if (off < (20 + gs) * sd) begin
            v[1] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [39:0] rand40();
        return {8'($urandom()), $urandom()};
    endfunction

    function automatic int sd_of(input int which);
        return (which == 0) ? 4 : 2;
    endfunction

    function automatic int gs_of(input int which);
        return (which == 0) ? 2 : 0;
    endfunction

    function automatic logic [4:0] obs(input int which);
        if (which == 0) return {i_a, q_a, se_a, busy_a, done_a};
        return {i_b, q_b, se_b, busy_b, done_b};
    endfunction

    task automatic set_in(input int which, input logic rst, input logic start, input logic [39:0] para);
        if (which == 0) begin
            rst_a = rst; start_a = start; para_a = para;
        end else begin
            rst_b = rst; start_b = start; para_b = para;
        end
    endtask

    // One frame from a single-cycle start pulse; para_i and start_i are scrambled in flight.
    task automatic run_frame(input int which, input logic [39:0] frame, input int mode, input string name);
        int sd, gs, p;
        sd = sd_of(which);
        gs = gs_of(which);
        p  = (20 + gs) * sd + 1;
        @(negedge clk);
        set_in(which, 1'b0, 1'b1, frame);
        n_sym = 0; done_off = -1; busy_fall = -1;
        for (int c = 0; c < p + 3; c++) begin
            logic [4:0]  vec, exp;
            logic [39:0] np;
            logic        st;
            @(negedge clk);
            vec = obs(which);
            exp = model(frame, c, sd, gs);
            total++;
            if (vec !== exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%b want=%b", name, c, vec, exp);
            end
            if (vec[2] === 1'b1) begin
                if (n_sym < 20) cap[n_sym] = vec[4:3];
                n_sym++;
            end
            if (vec[0] === 1'b1 && done_off < 0) done_off = c;
            if (c > 0 && vec[1] === 1'b0 && busy_fall < 0) busy_fall = c;
            np = (mode == 1) ? ((c >= 5 * sd) ? 40'hFFFFFFFFFF : frame) : rand40();
            st = (c < p - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            set_in(which, 1'b0, st, np);
        end
    endtask

    task automatic test_reset();
        logic [4:0] va, vb;
        set_in(0, 1'b1, 1'b0, rand40());
        set_in(1, 1'b1, 1'b0, rand40());
        repeat (3) @(negedge clk);
        va = obs(0);
        vb = obs(1);
        total++;
        if (va !== 5'b0) begin bad++; $display("FAIL reset_a got=%b want=00000", va); end
        total++;
        if (vb !== 5'b0) begin bad++; $display("FAIL reset_b got=%b want=00000", vb); end
        set_in(0, 1'b0, 1'b0, '0);
        set_in(1, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0] exp_iq [8];
        int idx [8];
        exp_iq = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
        idx    = '{0, 1, 2, 3, 16, 17, 18, 19};
        // para_i forced to all ones from symbol 5 on; the frame must not notice.
        run_frame(0, 40'hCC12345668, 1, "directed");
        total++;
        if (n_sym != 20) begin bad++; $display("FAIL dir_sym_count got=%0d want=20", n_sym); end
        total++;
        if (done_off != 80) begin bad++; $display("FAIL dir_done_off got=%0d want=80", done_off); end
        total++;
        if (busy_fall != 88) begin bad++; $display("FAIL dir_busy_fall got=%0d want=88", busy_fall); end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (cap[idx[j]] !== exp_iq[j]) begin
                bad++;
                $display("FAIL dir_sym%0d got=%b want=%b", idx[j], cap[idx[j]], exp_iq[j]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) run_frame(0, rand40(), 0, "rand_a");
        for (int n = 0; n < 3; n++) begin
            run_frame(1, rand40(), 0, "rand_b");
            total++;
            if (done_off != 40 || busy_fall != 40) begin
                bad++;
                $display("FAIL nogap_done_busy got=%0d/%0d want=40/40", done_off, busy_fall);
            end
        end
    endtask

    // start_i held high; frame n starts at n*period and carries para_i from the cycle before it.
    task automatic test_back_to_back(input int which, input int ncyc, input string name);
        int sd, gs, p;
        logic [4:0] vec;
        sd = sd_of(which);
        gs = gs_of(which);
        p  = (20 + gs) * sd + 1;
        @(negedge clk);
        hist[0] = rand40();
        set_in(which, 1'b0, 1'b1, hist[0]);
        for (int c = 0; c < ncyc; c++) begin
            logic [4:0] exp;
            @(negedge clk);
            vec = obs(which);
            exp = model(hist[(c / p) * p], c % p, sd, gs);
            total++;
            if (vec !== exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%b want=%b", name, c, vec, exp);
            end
            hist[c + 1] = rand40();
            set_in(which, 1'b0, 1'b1, hist[c + 1]);
        end
        @(negedge clk);
        set_in(which, 1'b0, 1'b0, '0);
        repeat (p + 2) @(negedge clk);
        vec = obs(which);
        total++;
        if (vec !== 5'b0) begin bad++; $display("FAIL %s_drain got=%b want=00000", name, vec); end
    endtask

    task automatic test_reset_mid();
        logic [39:0] f;
        logic [4:0]  vec, exp;
        f = rand40();
        @(negedge clk);
        set_in(0, 1'b0, 1'b1, f);
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            vec = obs(0);
            exp = (c <= 40) ? model(f, c, 4, 2) : 5'b0;
            total++;
            if (vec !== exp) begin
                bad++;
                $display("FAIL rst_mid cyc=%0d got=%b want=%b", c, vec, exp);
            end
            set_in(0, (c == 40), 1'b0, rand40());
        end
        // A request coinciding with reset is dropped.
        set_in(0, 1'b1, 1'b1, rand40());
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, '0);
        vec = obs(0);
        total++;
        if (vec !== 5'b0) begin bad++; $display("FAIL rst_start_drop got=%b want=00000", vec); end
        @(negedge clk);
        vec = obs(0);
        total++;
        if (vec !== 5'b0) begin bad++; $display("FAIL rst_start_drop2 got=%b want=00000", vec); end
        run_frame(0, 40'hCC12345668, 0, "after_rst");
        total++;
        if (n_sym != 20 || cap[0] !== 2'b11 || cap[19] !== 2'b00) begin
            bad++;
            $display("FAIL after_rst_frame got=%0d/%b/%b want=20/11/00", n_sym, cap[0], cap[19]);
        end
    endtask

    initial begin
        set_in(0, 1'b1, 1'b0, '0);
        set_in(1, 1'b1, 1'b0, '0);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back(0, 300, "b2b_a");
        test_back_to_back(1, 130, "b2b_b");
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qpsk_frame_ser.md
QPSK_FRAME_SER -- requirements
Module: qpsk_frame_ser

Interface
REQ-001 Parameter SYM_DIV, default 50: sys_clk cycles per QPSK symbol; legal range 2..65535.
REQ-002 Parameter GAP_SYM, default 4: idle symbol periods inserted after each frame; legal range 0..255.
REQ-003 sys_clk  input  1  sole clock; all logic on rising edge.
REQ-004 sys_rst  input  1  reset, synchronous, active-high.
REQ-005 para_i  input  40  frame {HEADER, hour, min, sec, checksum}, bit 39 first on air.
REQ-006 start_i  input  1  frame send request, level-sampled.
REQ-007 i_o  output  1  in-phase bit of current symbol.
REQ-008 q_o  output  1  quadrature bit of current symbol.
REQ-009 sym_en_o  output  1  one-cycle pulse marking the first cycle of each data symbol.
REQ-010 busy_o  output  1  high while a frame or its gap is in progress.
REQ-011 frame_done_o  output  1  one-cycle pulse when the last data symbol ends.

Function
REQ-012 FSM states SHALL be IDLE, SEND and GAP; all outputs are registered.
REQ-013 In IDLE with start_i=1, para_i SHALL be latched into a 40-bit shift register and the FSM SHALL enter SEND at the next edge.
REQ-014 Symbol k (k=0..19) SHALL carry i_o=frame[39-2k] and q_o=frame[38-2k], giving 20 symbols per frame.
REQ-015 Latency: in the first SEND cycle (one cycle after start_i is sampled), i_o/q_o SHALL show symbol 0, sym_en_o=1 and busy_o=1.
REQ-016 Each symbol SHALL hold i_o/q_o stable for exactly SYM_DIV cycles.
REQ-017 A cycle counter SHALL count 0..SYM_DIV-1 and wrap; at wrap the shift register advances 2 bits and the next symbol starts with sym_en_o=1.
REQ-018 sym_en_o SHALL pulse exactly 20 times per frame and never in IDLE or GAP.
REQ-019 After symbol 19 completes its SYM_DIV cycles, frame_done_o SHALL pulse for 1 cycle, coincident with the first cycle of GAP, or of IDLE if GAP_SYM=0.
REQ-020 GAP SHALL last GAP_SYM*SYM_DIV cycles with i_o=q_o=0 and busy_o=1, then return to IDLE.
REQ-021 In IDLE, i_o=q_o=0, busy_o=0, sym_en_o=0 and frame_done_o=0.
REQ-022 start_i SHALL be ignored in SEND and GAP; requests are not queued.
REQ-023 Changes on para_i after the latch cycle SHALL NOT affect the frame in flight.
REQ-024 If start_i is held high continuously, the next frame SHALL start 1 cycle after IDLE is re-entered; minimum frame period = (20+GAP_SYM)*SYM_DIV+1 cycles.
REQ-025 The symbol counter SHALL be wide enough for SYM_DIV-1, and the gap counter for GAP_SYM*SYM_DIV, with no overflow at maximum parameter values.

Reset
REQ-026 sys_rst=1 SHALL, at the next edge, force IDLE, all counters and the shift register to 0, and i_o=q_o=sym_en_o=busy_o=frame_done_o=0.
REQ-027 Reset asserted mid-SEND or mid-GAP SHALL abort the frame with no frame_done_o pulse.
REQ-028 start_i sampled while sys_rst=1 SHALL be discarded.
REQ-029 After reset release, start_i=1 SHALL begin a new frame following REQ-013 and REQ-015.

Verification
REQ-030 SYM_DIV=4, GAP_SYM=2, para_i=40'hCC12345668, 1-cycle start_i -> symbols 0..3 (I,Q) = (1,1),(0,0),(1,1),(0,0); symbols 16..19 = (0,1),(1,0),(1,0),(0,0); 20 sym_en_o pulses spaced 4 cycles apart.
REQ-031 Same setup -> frame_done_o exactly 81 cycles after start_i is sampled; busy_o falls 8 cycles later; i_o=q_o=0 during the gap.
REQ-032 start_i held high for 300 cycles -> frames start every 89 cycles; the second frame's latched data equals para_i at its own latch cycle.
REQ-033 para_i changed to 40'hFFFFFFFFFF during symbol 5 -> the transmitted symbols still match 40'hCC12345668.
REQ-034 sys_rst pulsed at symbol 10 -> outputs are 0 on the next cycle, no frame_done_o, and the next start_i transmits the full frame from symbol 0.
REQ-035 GAP_SYM=0, SYM_DIV=2 -> frame_done_o and busy_o=0 occur in the same cycle; a back-to-back period of 41 cycles is measured.
